// File: rtl/uart_word_bridge.sv
// Byte-to-word adapter between an 8-bit UART RX/TX pair and the debug controller.
// RX bytes are packed little-endian into words; TX words are unpacked into bytes.
module uart_word_bridge #(
    parameter int NBITS   = 32,
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBIT-1:0]  rx_byte,
    input  logic             rx_byte_done,
    output logic [NBITS-1:0] rx_Data,
    output logic             rx_done,
    output logic             rx_drop,
    input  logic [NBITS-1:0] tx_Data,
    input  logic             tx_start,
    output logic             tx_done,
    output logic             tx_busy,
    output logic [DBIT-1:0]  tx_byte,
    output logic             tx_byte_start,
    input  logic             tx_byte_done
);

    localparam int NBYTES = NBITS / DBIT;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN  = (TIMEOUT > 0);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NBYTES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_t;

    // RX state
    logic [CW-1:0]    rcnt_r;
    logic [IW-1:0]    idle_r;
    logic [NBITS-1:0] shadow_r;
    logic [NBITS-1:0] rx_data_r;
    logic             rx_done_r;
    logic             rx_drop_r;
    logic [NBITS-1:0] rx_word_s;
    logic             idle_hit_s;

    // TX state
    tx_state_t        tx_state_r;
    tx_state_t        tx_state_s;
    logic [NBITS-1:0] tx_shift_r;
    logic [NBITS-1:0] tx_shift_s;
    logic [CW-1:0]    tx_idx_r;
    logic [CW-1:0]    tx_idx_s;
    logic             tx_done_s;
    logic [DBIT-1:0]  tx_byte_r;
    logic             tx_byte_start_r;
    logic             tx_done_r;
    logic             tx_busy_r;

    assign rx_Data       = rx_data_r;
    assign rx_done       = rx_done_r;
    assign rx_drop       = rx_drop_r;
    assign tx_byte       = tx_byte_r;
    assign tx_byte_start = tx_byte_start_r;
    assign tx_done       = tx_done_r;
    assign tx_busy       = tx_busy_r;

    // Shadow word with the incoming byte merged into slot rcnt; idle-limit detect.
    always_comb begin
        rx_word_s = shadow_r;
        rx_word_s[rcnt_r*DBIT +: DBIT] = rx_byte;
        idle_hit_s = TO_EN && (rcnt_r != {CW{1'b0}}) && (idle_r == IDLE_LAST);
    end

    // RX byte assembly, word hand-off and stale-word timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt_r    <= {CW{1'b0}};
            idle_r    <= {IW{1'b0}};
            shadow_r  <= {NBITS{1'b0}};
            rx_data_r <= {NBITS{1'b0}};
            rx_done_r <= 1'b0;
            rx_drop_r <= 1'b0;
        end else begin
            rx_done_r <= 1'b0;
            rx_drop_r <= 1'b0;
            if (rx_byte_done) begin
                // A byte landing on the timeout edge takes priority over the drop
                idle_r   <= {IW{1'b0}};
                shadow_r <= rx_word_s;
                if (rcnt_r == LAST_IDX) begin
                    rx_data_r <= rx_word_s;
                    rx_done_r <= 1'b1;
                    rcnt_r    <= {CW{1'b0}};
                end else begin
                    rcnt_r <= rcnt_r + 1'b1;
                end
            end else if (idle_hit_s) begin
                rcnt_r    <= {CW{1'b0}};
                idle_r    <= {IW{1'b0}};
                rx_drop_r <= 1'b1;
            end else if (TO_EN && (rcnt_r != {CW{1'b0}})) begin
                idle_r <= idle_r + 1'b1;
            end else begin
                idle_r <= {IW{1'b0}};
            end
        end
    end

    // TX next-state logic; outputs are registered from the next-state values.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_shift_s = tx_shift_r;
        tx_idx_s   = tx_idx_r;
        tx_done_s  = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_shift_s = tx_Data;
                    tx_idx_s   = {CW{1'b0}};
                    tx_state_s = TX_SEND;
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_SEND: begin
                tx_state_s = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_byte_done) begin
                    if (tx_idx_r == LAST_IDX) begin
                        tx_state_s = TX_IDLE;
                        tx_done_s  = 1'b1;
                    end else begin
                        tx_shift_s = tx_shift_r >> DBIT;
                        tx_idx_s   = tx_idx_r + 1'b1;
                        tx_state_s = TX_SEND;
                    end
                end else begin
                    tx_state_s = TX_WAIT;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
            end
        endcase
    end

    // TX state and registered TX outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_r      <= TX_IDLE;
            tx_shift_r      <= {NBITS{1'b0}};
            tx_idx_r        <= {CW{1'b0}};
            tx_byte_r       <= {DBIT{1'b0}};
            tx_byte_start_r <= 1'b0;
            tx_done_r       <= 1'b0;
            tx_busy_r       <= 1'b0;
        end else begin
            tx_state_r      <= tx_state_s;
            tx_shift_r      <= tx_shift_s;
            tx_idx_r        <= tx_idx_s;
            tx_byte_r       <= tx_shift_s[DBIT-1:0];
            tx_byte_start_r <= (tx_state_s == TX_SEND);
            tx_done_r       <= tx_done_s;
            tx_busy_r       <= (tx_state_s != TX_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: RX assembly, TX serialization, timeout,
// reset abort and concurrent RX/TX, with a UART-transmitter responder model.
module tb_uart_word_bridge;

    localparam int NBITS   = 32;
    localparam int DBIT    = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [DBIT-1:0]  rx_byte;
    logic             rx_byte_done;
    logic [NBITS-1:0] rx_Data;
    logic             rx_done;
    logic             rx_drop;
    logic [NBITS-1:0] tx_Data;
    logic             tx_start;
    logic             tx_done;
    logic             tx_busy;
    logic [DBIT-1:0]  tx_byte;
    logic             tx_byte_start;
    logic             tx_byte_done;

    uart_word_bridge #(.NBITS(NBITS), .DBIT(DBIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .rx_byte(rx_byte), .rx_byte_done(rx_byte_done),
        .rx_Data(rx_Data), .rx_done(rx_done), .rx_drop(rx_drop),
        .tx_Data(tx_Data), .tx_start(tx_start),
        .tx_done(tx_done), .tx_busy(tx_busy),
        .tx_byte(tx_byte), .tx_byte_start(tx_byte_start),
        .tx_byte_done(tx_byte_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse/byte monitor, sampled on the inactive edge
    int        rx_done_cnt = 0;
    int        drop_cnt    = 0;
    int        tx_done_cnt = 0;
    logic [7:0] txq[$];

    always @(negedge clk) begin
        if (rx_done === 1'b1) rx_done_cnt++;
        if (rx_drop === 1'b1) drop_cnt++;
        if (tx_done === 1'b1) tx_done_cnt++;
        if (tx_byte_start === 1'b1) txq.push_back(tx_byte);
    end

    // UART transmitter model: answers tx_byte_done ~5 cycles after each start
    logic [7:0] resp_byte;
    initial begin
        tx_byte_done = 1'b0;
        forever begin
            if (tx_byte_start === 1'b1 && reset === 1'b0) begin
                resp_byte = tx_byte;
                repeat (4) @(negedge clk);
                if (tx_busy === 1'b1 && reset === 1'b0) check("tx_hold", tx_byte, resp_byte);
                tx_byte_done = 1'b1;
                @(negedge clk);
                tx_byte_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // All driving tasks are entered and left on a falling edge
    task automatic send_rx(input logic [7:0] b);
        rx_byte      = b;
        rx_byte_done = 1'b1;
        @(negedge clk);
        rx_byte_done = 1'b0;
    endtask

    task automatic start_tx(input logic [31:0] w);
        tx_Data  = w;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_tx_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_done === 1'b1) break;
        end
        check(tag, tx_done, 1'b1);
    endtask

    task automatic check_txq(input string tag, input int off, input logic [31:0] w);
        logic [7:0] got;
        for (int i = 0; i < 4; i++) begin
            got = (off + i < txq.size()) ? txq[off + i] : 8'hxx;
            check(tag, got, w[8*i +: 8]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_Data"}, rx_Data, 32'h0);
        check({tag, "_ctl"}, {rx_done, rx_drop, tx_done, tx_busy, tx_byte_start, tx_byte}, 13'h0);
    endtask

    int   base_rx, base_tx, base_drop, base_q, n;
    logic early;

    initial begin
        reset        = 1'b1;
        rx_byte      = 8'h00;
        rx_byte_done = 1'b0;
        tx_Data      = 32'h0;
        tx_start     = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // RX: spaced bytes, then back-to-back
        send_rx(8'h00); repeat (9) @(negedge clk);
        send_rx(8'h10); repeat (9) @(negedge clk);
        send_rx(8'h00); repeat (9) @(negedge clk);
        send_rx(8'h10);
        check("rx_done_lat", rx_done, 1'b1);
        check("rx_word0", rx_Data, 32'h10001000);
        @(negedge clk);
        check("rx_done_pulse", rx_done, 1'b0);
        check("rx_word0_hold", rx_Data, 32'h10001000);
        for (int i = 0; i < 4; i++) send_rx(8'hFF);
        check("rx_word1_done", rx_done, 1'b1);
        check("rx_word1", rx_Data, 32'hFFFFFFFF);
        @(posedge clk);
        check("rx_done_count", rx_done_cnt, 2);
        txq.delete();
        base_tx = tx_done_cnt;
        @(negedge clk);

        // TX: single word
        start_tx(32'h45003000);
        check("tx_start_lat", tx_byte_start, 1'b1);
        check("tx_byte0", tx_byte, 8'h00);
        check("tx_busy_on", tx_busy, 1'b1);
        wait_tx_done("tx_done0");
        check("tx_busy_in_done", tx_busy, 1'b0);
        @(negedge clk);
        check("tx_done_pulse", tx_done, 1'b0);
        check("tx_busy_after", tx_busy, 1'b0);
        @(posedge clk);
        check("tx_q_size0", txq.size(), 4);
        check_txq("tx_bytes0", 0, 32'h45003000);
        check("tx_done_count0", tx_done_cnt - base_tx, 1);
        txq.delete();
        @(negedge clk);

        // TX: start during busy ignored, start in tx_done cycle accepted
        start_tx(32'h45003000);
        n = 0;
        for (int i = 0; i < 100 && n < 1; i++) begin
            @(negedge clk);
            if (tx_byte_start === 1'b1) n++;
        end
        check("tx_reach_b1", n, 1);
        @(negedge clk);
        start_tx(32'hDEADBEEF);
        check("tx_busy_ignore", tx_byte_start, 1'b0);
        wait_tx_done("tx_done1");
        start_tx(32'h11223344);
        check("tx_start_in_done", tx_byte_start, 1'b1);
        check("tx_byte0_b2b", tx_byte, 8'h44);
        wait_tx_done("tx_done2");
        @(posedge clk);
        check("tx_q_size1", txq.size(), 8);
        check_txq("tx_bytes1", 0, 32'h45003000);
        check_txq("tx_bytes2", 4, 32'h11223344);
        base_drop = drop_cnt;
        base_rx   = rx_done_cnt;
        @(negedge clk);

        // Timeout discards a partial word
        send_rx(8'hAA);
        send_rx(8'hBB);
        early = 1'b0;
        for (int j = 1; j < TIMEOUT; j++) begin
            @(negedge clk);
            early = early | rx_drop;
        end
        check("no_early_drop", early, 1'b0);
        @(negedge clk);
        check("rx_drop", rx_drop, 1'b1);
        check("rx_drop_keep", rx_Data, 32'hFFFFFFFF);
        @(negedge clk);
        check("rx_drop_pulse", rx_drop, 1'b0);
        send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
        check("rx_word2_done", rx_done, 1'b1);
        check("rx_word2", rx_Data, 32'h12345678);

        // A byte on the timeout edge wins over the drop
        send_rx(8'hAA);
        repeat (TIMEOUT - 1) @(negedge clk);
        send_rx(8'hBB);
        check("race_no_drop", rx_drop, 1'b0);
        send_rx(8'hCC); send_rx(8'hDD);
        check("rx_word3", rx_Data, 32'hDDCCBBAA);
        @(posedge clk);
        check("drop_count", drop_cnt - base_drop, 1);
        check("rx_done_count2", rx_done_cnt - base_rx, 2);
        @(negedge clk);

        // Reset mid-operation
        send_rx(8'h55); send_rx(8'h66);
        start_tx(32'hCAFEF00D);
        n = 0;
        for (int i = 0; i < 100 && n < 2; i++) begin
            @(negedge clk);
            if (tx_byte_start === 1'b1) n++;
        end
        check("rst_reach_b2", n, 2);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        @(posedge clk);
        base_q  = txq.size();
        base_tx = tx_done_cnt;
        repeat (20) @(posedge clk);
        check("rst_no_tx_start", txq.size() - base_q, 0);
        check("rst_no_tx_done", tx_done_cnt - base_tx, 0);
        @(negedge clk);
        check("rst_busy_low", tx_busy, 1'b0);
        send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
        check("rx_word4", rx_Data, 32'h04030201);
        repeat (4) @(negedge clk);
        @(posedge clk);
        txq.delete();
        base_rx = rx_done_cnt;
        base_tx = tx_done_cnt;
        @(negedge clk);

        // Concurrent RX and TX
        fork
            begin
                send_rx(8'h0F); repeat (2) @(negedge clk);
                send_rx(8'h00); repeat (2) @(negedge clk);
                send_rx(8'h00); repeat (2) @(negedge clk);
                send_rx(8'h00);
                check("cc_rx_done", rx_done, 1'b1);
                check("cc_rx_word", rx_Data, 32'h0000000F);
            end
            begin
                start_tx(32'h00000FFF);
                wait_tx_done("cc_tx_done");
            end
        join
        @(posedge clk);
        check("cc_q_size", txq.size(), 4);
        check_txq("cc_tx_bytes", 0, 32'h00000FFF);
        check("cc_rx_count", rx_done_cnt - base_rx, 1);
        check("cc_tx_count", tx_done_cnt - base_tx, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
